// File: rtl/mv_result_collect.sv
// Result collector for the systolic MV array: captures staggered per-row accumulator
// results, saturates them, and presents packed vectors from a two-bank buffer over valid/ready.

module mv_sat_lane #(
   parameter int ACC_W = 20,
   parameter int WIDTH = 8
) (
   input  logic [ACC_W-1:0] i_acc,
   output logic [WIDTH-1:0] o_val,
   output logic             o_clamp
);
   logic [ACC_W-WIDTH:0] w_hi;

   // The value fits iff every bit above the output sign bit matches the accumulator sign.
   assign w_hi    = i_acc[ACC_W-1:WIDTH-1];
   assign o_clamp = !((&w_hi) || !(|w_hi));
   assign o_val   = !o_clamp        ? i_acc[WIDTH-1:0] :
                    i_acc[ACC_W-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                      {1'b0, {(WIDTH-1){1'b1}}};
endmodule

module mv_result_collect #(
   parameter int DIMENSION = 16,
   parameter int WIDTH     = 8,
   parameter int ACC_W     = 20
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DIMENSION-1:0]       row_valid,
   input  logic [DIMENSION*ACC_W-1:0] row_data,
   output logic                       mv_valid,
   input  logic                       mv_ready,
   output logic [DIMENSION*WIDTH-1:0] mv_data,
   output logic                       mv_sat,
   output logic                       busy,
   output logic                       overflow,
   input  logic                       clr_ovf
);
   typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;

   bank_st_t                                r_state [0:1];
   logic [1:0][DIMENSION-1:0][WIDTH-1:0]    r_data;
   logic [1:0][DIMENSION-1:0]               r_got;
   logic [1:0]                              r_sat;
   logic                                    r_wr;
   logic                                    r_rd;
   logic                                    r_ovf;

   logic [DIMENSION-1:0][WIDTH-1:0]         w_sat_val;
   logic [DIMENSION-1:0]                    w_clamp;
   logic [DIMENSION-1:0]                    w_new;
   logic [DIMENSION-1:0]                    w_dup;
   logic [DIMENSION-1:0]                    w_got_nxt;
   logic                                    w_wr_full;
   logic                                    w_drop;
   logic                                    w_done;
   logic                                    w_new_sat;
   logic                                    w_accept;

   for (genvar g = 0; g < DIMENSION; g++) begin : g_lane
      mv_sat_lane #(.ACC_W(ACC_W), .WIDTH(WIDTH)) u_sat (
         .i_acc   (row_data[g*ACC_W +: ACC_W]),
         .o_val   (w_sat_val[g]),
         .o_clamp (w_clamp[g])
      );
   end

   always_comb begin
      w_wr_full = (r_state[r_wr] == FULL);
      w_new     = w_wr_full ? '0 : (row_valid & ~r_got[r_wr]);
      w_dup     = w_wr_full ? '0 : (row_valid &  r_got[r_wr]);
      w_drop    = w_wr_full && (|row_valid);
      w_got_nxt = r_got[r_wr] | w_new;
      // Completion counts same-cycle strobes; nothing spills into the other bank.
      w_done    = !w_wr_full && (&w_got_nxt);
      w_new_sat = |(w_new & w_clamp);
      w_accept  = (r_state[r_rd] == FULL) && mv_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state[0] <= EMPTY;
         r_state[1] <= EMPTY;
         r_data     <= '0;
         r_got      <= '0;
         r_sat      <= '0;
         r_wr       <= 1'b0;
         r_rd       <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         for (int i = 0; i < DIMENSION; i++)
            if (w_new[i]) r_data[r_wr][i] <= w_sat_val[i];
         if (!w_wr_full) begin
            r_sat[r_wr] <= r_sat[r_wr] | w_new_sat;
            if (w_done) begin
               r_got[r_wr]   <= '0;
               r_state[r_wr] <= FULL;
               r_wr          <= ~r_wr;
            end else begin
               r_got[r_wr] <= w_got_nxt;
               if (|w_new) r_state[r_wr] <= FILLING;
            end
         end
         // Accept only touches a FULL bank, which capture never writes the same cycle.
         if (w_accept) begin
            r_state[r_rd] <= EMPTY;
            r_sat[r_rd]   <= 1'b0;
            r_rd          <= ~r_rd;
         end
         if (w_drop || (|w_dup)) r_ovf <= 1'b1;
         else if (clr_ovf)       r_ovf <= 1'b0;
      end
   end

   assign mv_valid = (r_state[r_rd] == FULL);
   assign mv_data  = mv_valid ? r_data[r_rd] : '0;
   assign mv_sat   = mv_valid && r_sat[r_rd];
   assign busy     = (r_state[r_wr] == FILLING);
   assign overflow = r_ovf;
endmodule

// File: tb/tb_mv_result_collect.sv
// Directed bench for mv_result_collect: queue-based reference model checked every cycle,
// plus literal expectations on key cycles.

module tb_mv_result_collect;
   localparam int D = 16;
   localparam int W = 8;
   localparam int A = 20;
   localparam int MAXV = 2**(W-1) - 1;
   localparam int MINV = -(2**(W-1));
   localparam logic [D*W-1:0] LIT_A = 128'h100F0E0D0C0B0A090807060504030201;
   localparam logic [D*W-1:0] LIT_S = 128'hFB807F;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [D-1:0]          row_valid = '0;
   logic [D-1:0][A-1:0]   row_data = '0;
   logic                  mv_ready = 1'b0;
   logic                  clr_ovf = 1'b0;
   logic                  mv_valid, mv_sat, busy, overflow;
   logic [D*W-1:0]        mv_data;

   int checks = 0;
   int failures = 0;
   bit chk_en = 0;

   mv_result_collect #(.DIMENSION(D), .WIDTH(W), .ACC_W(A)) dut (
      .clk(clk), .rst(rst), .row_valid(row_valid), .row_data(row_data),
      .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_data(mv_data), .mv_sat(mv_sat),
      .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [D*W-1:0] got, input logic [D*W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: queue of completed vectors (at most two banks' worth) plus
   // the batch currently being gathered.
   logic [D*W-1:0] mq[$];
   bit             msq[$];
   int             fill_v[D];
   bit             fill_got[D];
   bit             fill_sat;
   bit             m_ovf;

   function automatic int satv(input int v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   always @(posedge clk) begin
      int  sz;
      bit  ovf_set, all_got;
      logic [D*W-1:0] vec;
      if (rst) begin
         mq.delete(); msq.delete();
         foreach (fill_got[i]) begin fill_got[i] = 0; fill_v[i] = 0; end
         fill_sat = 0; m_ovf = 0;
      end else begin
         sz = mq.size();
         ovf_set = 0;
         for (int r = 0; r < D; r++) begin
            if (row_valid[r]) begin
               if (sz == 2) ovf_set = 1;
               else if (fill_got[r]) ovf_set = 1;
               else begin
                  int v;
                  v = $signed(row_data[r]);
                  fill_got[r] = 1;
                  fill_v[r] = satv(v);
                  if (satv(v) != v) fill_sat = 1;
               end
            end
         end
         all_got = 1;
         foreach (fill_got[i]) if (!fill_got[i]) all_got = 0;
         if (sz > 0 && mv_ready) begin void'(mq.pop_front()); void'(msq.pop_front()); end
         if (sz < 2 && all_got) begin
            for (int i = 0; i < D; i++) vec[i*W +: W] = fill_v[i][W-1:0];
            mq.push_back(vec); msq.push_back(fill_sat);
            foreach (fill_got[i]) fill_got[i] = 0;
            fill_sat = 0;
         end
         if (ovf_set) m_ovf = 1;
         else if (clr_ovf) m_ovf = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit anyg;
         anyg = 0;
         foreach (fill_got[i]) if (fill_got[i]) anyg = 1;
         check("mv_valid", mv_valid, mq.size() > 0);
         check("mv_data", mv_data, (mq.size() > 0) ? mq[0] : '0);
         check("mv_sat", mv_sat, (msq.size() > 0) ? msq[0] : 1'b0);
         check("busy", busy, anyg);
         check("overflow", overflow, m_ovf);
      end
   end

   logic [D-1:0][A-1:0] bat;

   task automatic step(input logic [D-1:0] v, input logic [D-1:0][A-1:0] d);
      @(posedge clk); #1;
      row_valid = v; row_data = d;
   endtask

   task automatic stream();
      for (int r = 0; r < D; r++) step(D'(1) << r, bat);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0);
   endtask

   task automatic fill_bat(input int base);
      for (int r = 0; r < D; r++) bat[r] = A'(base + r);
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1; clr_ovf = 1'b1;
      @(posedge clk); #1; clr_ovf = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      chk_en = 1;
      @(negedge clk);
      check("rst_valid", mv_valid, 0);
      check("rst_data", mv_data, 0);
      check("rst_sat", mv_sat, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);

      // Nominal stagger with consumer always ready
      mv_ready = 1'b1;
      fill_bat(1);
      stream();
      idle(1);
      @(negedge clk);
      check("nom_valid", mv_valid, 1);
      check("nom_data", mv_data, LIT_A);
      check("nom_sat", mv_sat, 0);
      // Back-to-back batches at full rate
      stream(); stream();
      idle(3);
      @(negedge clk);
      check("thru_ovf", overflow, 0);

      // Saturation
      bat = '0;
      bat[0] = A'(300); bat[1] = A'(-200); bat[2] = A'(-5);
      stream();
      idle(1);
      @(negedge clk);
      check("sat_data", mv_data, LIT_S);
      check("sat_flag", mv_sat, 1);
      idle(2);

      // Back-pressure: A held, B buffered, C dropped
      mv_ready = 1'b0;
      fill_bat(1);   stream();
      fill_bat(101); stream();
      fill_bat(201); stream();
      idle(1);
      @(negedge clk);
      check("bp_valid", mv_valid, 1);
      check("bp_dataA", mv_data, LIT_A);
      check("bp_ovf", overflow, 1);
      @(posedge clk); #1; mv_ready = 1'b1;
      @(negedge clk);
      check("bp_dataA_last", mv_data, LIT_A);
      @(negedge clk);
      check("bp_dataB", mv_data[7:0], 8'h65);
      @(negedge clk);
      check("bp_drained", mv_valid, 0);
      pulse_clr();
      @(negedge clk);
      check("bp_clr", overflow, 0);

      // All rows in one cycle
      for (int r = 0; r < D; r++) bat[r] = A'(-r);
      step('1, bat);
      idle(1);
      @(negedge clk);
      check("all_valid", mv_valid, 1);
      check("all_busy", busy, 0);
      idle(2);

      // Duplicate strobe for row 3
      fill_bat(10);
      for (int r = 0; r < 6; r++) step(D'(1) << r, bat);
      bat[3] = A'(99);
      step(D'(1) << 3, bat);
      for (int r = 6; r < D; r++) step(D'(1) << r, bat);
      idle(1);
      @(negedge clk);
      check("dup_ovf", overflow, 1);
      check("dup_elem3", mv_data[31:24], 8'h0D);
      pulse_clr();
      idle(1);

      // Reset mid-batch
      fill_bat(50);
      for (int r = 0; r < 8; r++) step(D'(1) << r, bat);
      idle(1);
      @(negedge clk);
      check("pre_rst_busy", busy, 1);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_valid", mv_valid, 0);
      fill_bat(1);
      stream();
      idle(1);
      @(negedge clk);
      check("post_rst_data", mv_data, LIT_A);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
